spi_divider: RTL and testbench
==============================

Name: spi_divider

Overview:
- Sequential unsigned divider peripheral on the processor's shared SPI bus, alongside the ALU, barrel shifter and multiplier slaves.
- Receives one operand packet (mode, dividend, divisor) from the processor, computes quotient or remainder with a restoring shift-subtract algorithm (one bit per cycle), then returns a DATA_WIDTH-bit result.
- Uses the same serial protocol as the other slaves:
  - start bit on MOSI, then packet LSB first;
  - start bit on MISO, then result LSB first.

Parameters:
- NssPosition, 3, index of this slave's select line in spi.nss.
- NssWidth, 4, width of spi.nss (one bit per slave on the bus).
- DATA_WIDTH, 8, operand and result width; must match the processor register width.

Ports:
- i_clock  input  1  system clock; also drives spi.sclk.
- i_reset  input  1  asynchronous, active-low reset.
- spi.sclk  input  1  serial clock, equal to i_clock; all sampling on posedge.
- spi.nss  input  NssWidth  active-low selects; only bit NssPosition is used.
- spi.mosi  input  1  master-to-slave serial data.
- spi.miso  output  1  slave-to-master serial data; high-Z when nss[NssPosition]=1.

Behaviour:
- Packet, P = 2*DATA_WIDTH+1 bits, LSB first:
  - bit0 = mode (0 quotient, 1 remainder);
  - bits[DATA_WIDTH:1] = dividend;
  - bits[2*DATA_WIDTH:DATA_WIDTH+1] = divisor.
- States: IDLE, RX, DIVIDE, TX_START, TX, plus internal counters bit_cnt and div_cnt.
- Reset (async, i_reset=0):
  - state=IDLE; all shift registers and counters = 0;
  - miso = 0 if selected, else Z.
- IDLE:
  - miso=0 while selected (the master waits for miso=0 with mosi=1).
  - At a posedge with nss[NssPosition]=0 and mosi=1 (start bit): go to RX, bit_cnt=0.
- RX:
  - Each posedge: packet[bit_cnt] <= mosi.
  - After bit P-1 is sampled: go to DIVIDE with div_cnt=0; partial remainder R=0; Q=dividend.
  - Exactly P cycles in RX.
- DIVIDE:
  - DATA_WIDTH cycles, one per bit, MSB first.
  - Each cycle: {R,Q} shifted left by 1; then if R >= divisor, R -= divisor and Q[0]=1.
  - Use a DATA_WIDTH+1-bit compare/subtract; no overflow.
  - After the last cycle: result = mode ? R : Q; go to TX_START.
- Divisor == 0:
  - Skip iteration and go to TX_START on the next cycle.
  - Quotient = all ones; remainder = dividend.
- TX_START:
  - miso=1 for exactly one cycle (the master moves to its receive phase when miso=1 and mosi=0).
  - Then go to TX, bit_cnt=0.
- TX:
  - miso = result[bit_cnt] for one cycle per bit, LSB first, for DATA_WIDTH cycles.
  - Then return to IDLE with miso=0.
- Latency from start-bit sample to MISO start bit:
  - P + DATA_WIDTH + 1 cycles normally;
  - P + 1 cycles when divisor = 0.
- Deselect (nss[NssPosition]=1) in any non-IDLE state:
  - abort to IDLE at the next posedge; discard partial data; miso goes Z.
- Start bit ignored:
  - in any state other than IDLE;
  - while deselected, regardless of mosi.
- mosi is ignored in DIVIDE, TX_START and TX; it stays 0 from the master during those states.
- Back-to-back transactions: a new start bit is accepted on the first IDLE cycle after TX completes.
- Mid-operation async reset: immediate return to IDLE; outputs at reset values; no result emitted.

Test Plan:
- Quotient: W=8, mode=0, dividend=100, divisor=7, nss low → MISO start bit exactly P+W+1=26 cycles after the MOSI start sample, then bits LSB first for 14 (0x0E).
- Remainder and exact division:
  - mode=1, dividend=100, divisor=7 → returns 2;
  - mode=1, dividend=255, divisor=255 → returns 0;
  - mode=0 on the same operands → returns 1.
- Divide by zero: dividend=0x5A, divisor=0:
  - mode=0 → 0xFF; mode=1 → 0x5A;
  - MISO start bit P+1=18 cycles after the start sample.
- Abort: raise nss[NssPosition] after 5 RX bits → IDLE next cycle, miso Z. A following full transaction 9/2 mode=0 → returns 4.
- Selection isolation:
  - start bit driven with only another slave's nss low → no response, miso stays Z;
  - start bit during DIVIDE → ignored, result unaffected.
- Reset mid-TX: assert i_reset after 3 result bits → state IDLE asynchronously, miso 0/Z. A next transaction 200/3 mode=0 → returns 66.

Source files
------------

// File: rtl/spi_divider.sv
// Serial unsigned divider slave on the shared SPI bus: receives {divisor, dividend, mode}
// LSB first, runs a restoring shift-subtract divide, and returns quotient or remainder.
module spi_divider #(
    parameter int NssPosition = 3,
    parameter int NssWidth    = 4,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                spi_sclk,
    input  logic [NssWidth-1:0] spi_nss,
    input  logic                spi_mosi,
    output logic                spi_miso
);

    localparam int P     = 2 * DATA_WIDTH + 1;
    localparam int CntW  = (P > 1) ? $clog2(P) : 1;
    localparam int DivW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int IdxW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CntW-1:0] LastRxBit  = CntW'(P - 1);
    localparam logic [CntW-1:0] LastTxBit  = CntW'(DATA_WIDTH - 1);
    localparam logic [DivW-1:0] LastDivBit = DivW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        RX,
        DIVIDE,
        TX_START,
        TX
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         bitCnt_q, bitCnt_d;
    logic [DivW-1:0]         divCnt_q, divCnt_d;
    logic [P-1:0]            packet_q, packet_d;
    logic [DATA_WIDTH-1:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0]   quo_q, quo_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;

    logic                    selected;
    logic                    misoOut;
    logic [P-1:0]            rxPacket;
    logic [DATA_WIDTH-1:0]   rxDividend, rxDivisor;
    logic [DATA_WIDTH-1:0]   divisor;
    logic [DATA_WIDTH:0]     shifted, trialDiff;
    logic                    fits;
    logic [DATA_WIDTH-1:0]   remNext, quoNext;
    logic                    unusedSignals;

    assign selected      = ~spi_nss[NssPosition];
    assign unusedSignals = ^{spi_sclk, spi_nss};

    always_comb begin
        rxPacket           = packet_q;
        rxPacket[bitCnt_q] = spi_mosi;
    end

    assign rxDividend = rxPacket[DATA_WIDTH:1];
    assign rxDivisor  = rxPacket[2*DATA_WIDTH:DATA_WIDTH+1];
    assign divisor    = packet_q[2*DATA_WIDTH:DATA_WIDTH+1];

    // One restoring step: shift {R,Q} left, then subtract the divisor if it fits.
    assign shifted   = {rem_q, quo_q[DATA_WIDTH-1]};
    assign trialDiff = shifted - {1'b0, divisor};
    assign fits      = (shifted >= {1'b0, divisor});
    assign remNext   = fits ? trialDiff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    assign quoNext   = (quo_q << 1) | DATA_WIDTH'(fits);

    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        divCnt_d = divCnt_q;
        packet_d = packet_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        misoOut  = 1'b0;

        case (state_q)
            IDLE: begin
                if (selected && spi_mosi) begin
                    state_d  = RX;
                    bitCnt_d = '0;
                end
            end
            RX: begin
                packet_d = rxPacket;
                if (bitCnt_q == LastRxBit) begin
                    // A zero divisor bypasses the iteration so the answer is ready one cycle later.
                    if (rxDivisor == '0) begin
                        state_d  = TX_START;
                        result_d = rxPacket[0] ? rxDividend : '1;
                    end else begin
                        state_d  = DIVIDE;
                        divCnt_d = '0;
                        rem_d    = '0;
                        quo_d    = rxDividend;
                    end
                end else begin
                    bitCnt_d = bitCnt_q + 1'b1;
                end
            end
            DIVIDE: begin
                rem_d = remNext;
                quo_d = quoNext;
                if (divCnt_q == LastDivBit) begin
                    state_d  = TX_START;
                    result_d = packet_q[0] ? remNext : quoNext;
                end else begin
                    divCnt_d = divCnt_q + 1'b1;
                end
            end
            TX_START: begin
                misoOut  = 1'b1;
                state_d  = TX;
                bitCnt_d = '0;
            end
            TX: begin
                misoOut = result_q[bitCnt_q[IdxW-1:0]];
                if (bitCnt_q == LastTxBit) begin
                    state_d  = IDLE;
                    bitCnt_d = '0;
                end else begin
                    bitCnt_d = bitCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!selected && state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            divCnt_q <= '0;
            packet_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            divCnt_q <= divCnt_d;
            packet_q <= packet_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
        end
    end

    assign spi_miso = selected ? misoOut : 1'bz;

endmodule

// File: tb/tb_spi_divider.sv
// Randomized and directed bench for spi_divider; results and latencies come from a
// plain arithmetic model of the divide operation.
module tb_spi_divider;

    localparam int DW      = 8;
    localparam int P       = 2 * DW + 1;
    localparam int NssPos  = 3;
    localparam int NssW    = 4;
    localparam logic [NssW-1:0] SEL   = 4'b0111;
    localparam logic [NssW-1:0] OTHER = 4'b1110;
    localparam logic [NssW-1:0] NONE  = 4'b1111;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NssW-1:0] nss   = NONE;
    logic            mosi  = 1'b0;
    wire             miso;

    int errors = 0;
    int checks = 0;

    // An undriven miso reads as 1 here, which is how a released line is told apart from a driven 0.
    pullup (miso);

    always #5 clock = ~clock;

    spi_divider #(
        .NssPosition(NssPos),
        .NssWidth   (NssW),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clock (clock),
        .i_reset (reset),
        .spi_sclk(clock),
        .spi_nss (nss),
        .spi_mosi(mosi),
        .spi_miso(miso)
    );

    function automatic logic [DW-1:0] refResult(input logic m, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        if (b == 0) return m ? a : {DW{1'b1}};
        return m ? (a % b) : (a / b);
    endfunction

    function automatic int refLatency(input logic [DW-1:0] b);
        return (b == 0) ? (P + 1) : (P + DW + 1);
    endfunction

    // Full transaction; starts on the next negedge so back-to-back calls hit the first IDLE cycle.
    task automatic runTxn(input logic m, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input bit poke, input int resetAfter, input string name);
        logic [P-1:0]  pkt;
        logic [DW-1:0] expected;
        logic [DW-1:0] got;
        int            startJ;
        int            expLat;
        pkt      = {b, a, m};
        expected = refResult(m, a, b);
        expLat   = refLatency(b);
        startJ   = -1;
        got      = '0;
        @(negedge clock);
        checks++;
        if (miso !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_idle: miso=%b required 0", name, miso);
        end
        mosi = 1'b1;
        for (int j = 0; j < P + DW + 12 && startJ < 0; j++) begin
            @(negedge clock);
            if (j < P) begin
                mosi = pkt[j];
            end else begin
                mosi = (poke && j == P + 2) ? 1'b1 : 1'b0;
                if (miso === 1'b1) startJ = j;
            end
        end
        mosi = 1'b0;
        checks++;
        if (startJ + 1 != expLat) begin
            errors++;
            $display("[TB] FAIL %s_latency: got %0d cycles required %0d", name, startJ + 1, expLat);
            return;
        end
        for (int k = 0; k < DW; k++) begin
            @(negedge clock);
            if (k == resetAfter) begin
                reset = 1'b0;
                #1;
                checks++;
                if (miso !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s_reset_miso: miso=%b required 0", name, miso);
                end
                #1 reset = 1'b1;
                return;
            end
            got[k] = miso;
        end
        checks++;
        if (got !== expected) begin
            errors++;
            $display("[TB] FAIL %s_result: got 0x%0h required 0x%0h", name, got, expected);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if (miso !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_deselected: miso=%b required Z", miso);
        end
        nss = SEL;
        #1;
        checks++;
        if (miso !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_selected: miso=%b required 0", miso);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_quotient();
        runTxn(1'b0, 8'd100, 8'd7, 1'b0, -1, "quot_100_7");
    endtask

    task automatic test_remainder();
        runTxn(1'b1, 8'd100, 8'd7, 1'b0, -1, "rem_100_7");
        runTxn(1'b1, 8'd255, 8'd255, 1'b0, -1, "rem_255_255");
        runTxn(1'b0, 8'd255, 8'd255, 1'b0, -1, "quot_255_255");
    endtask

    task automatic test_div_zero();
        runTxn(1'b0, 8'h5A, 8'd0, 1'b0, -1, "quot_div0");
        runTxn(1'b1, 8'h5A, 8'd0, 1'b0, -1, "rem_div0");
    endtask

    task automatic test_abort();
        logic [P-1:0] pkt;
        pkt = {8'd13, 8'hB7, 1'b1};
        @(negedge clock);
        mosi = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            mosi = pkt[i];
        end
        @(negedge clock);
        nss  = NONE;
        mosi = 1'b0;
        #1;
        checks++;
        if (miso !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_release: miso=%b required Z", miso);
        end
        @(negedge clock);
        nss = SEL;
        #1;
        checks++;
        if (miso !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_idle: miso=%b required 0", miso);
        end
        runTxn(1'b0, 8'd9, 8'd2, 1'b0, -1, "after_abort");
    endtask

    task automatic test_isolation();
        @(negedge clock);
        nss = OTHER;
        for (int i = 0; i < 6; i++) begin
            mosi = 1'b1;
            @(negedge clock);
            checks++;
            if (miso !== 1'b1) begin
                errors++;
                $display("[TB] FAIL isolation_z_%0d: miso=%b required Z", i, miso);
            end
        end
        mosi = 1'b0;
        nss  = SEL;
        runTxn(1'b0, 8'd100, 8'd7, 1'b1, -1, "start_in_divide");
    endtask

    task automatic test_reset_mid_tx();
        runTxn(1'b0, 8'd100, 8'd7, 1'b0, 3, "reset_mid_tx");
        runTxn(1'b0, 8'd200, 8'd3, 1'b0, -1, "after_reset");
    endtask

    task automatic test_back_to_back();
        runTxn(1'b0, 8'd250, 8'd9, 1'b0, -1, "b2b_first");
        runTxn(1'b1, 8'd250, 8'd9, 1'b0, -1, "b2b_second");
    endtask

    task automatic test_random();
        logic          m;
        logic [DW-1:0] a, b;
        for (int n = 0; n < 16; n++) begin
            m = 1'($urandom_range(0, 1));
            a = DW'($urandom_range(0, 255));
            b = ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom_range(1, 255));
            runTxn(m, a, b, 1'($urandom_range(0, 1)) && (b != 0), -1, "random");
        end
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_quotient();
        test_remainder();
        test_div_zero();
        test_abort();
        test_isolation();
        test_reset_mid_tx();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
